// File: rtl/gate_sweep_checker.sv
// gate_sweep_checker
//   Sweeps every input combination of an N_IN-input gate in ascending order,
//   holds each vector SETTLE cycles, samples the gate output and compares it
//   against a reduction reference (AND/OR/XOR and complements).
//
// Ports
//   clk, rst          clock, asynchronous active-high reset
//   start, abort      sweep request (IDLE only) / sweep termination
//   mode[2:0]         reference function, latched on accepted start
//   dut_in[N_IN-1:0]  registered stimulus to the gate under test
//   dut_y             gate-under-test output
//   busy, done        sweep running / one-cycle completion pulse
//   pass              last completed sweep had no mismatches
//   err_count         mismatch count
//   first_fail_vec    first mismatching vector, valid with first_fail_valid
//   cfg_err           one-cycle pulse for a start with a reserved mode
//
// State  | meaning
// IDLE   | waiting for start
// RUN    | stepping vectors, sampling dut_y at the end of each settle window
// DONE   | one-cycle completion, start ignored
module gate_sweep_checker #(
   parameter int N_IN   = 2,
   parameter int SETTLE = 1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic            abort,
   input  logic [2:0]      mode,
   output logic [N_IN-1:0] dut_in,
   input  logic            dut_y,
   output logic            busy,
   output logic            done,
   output logic            pass,
   output logic [N_IN:0]   err_count,
   output logic [N_IN-1:0] first_fail_vec,
   output logic            first_fail_valid,
   output logic            cfg_err
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   localparam logic [3:0]      SETTLE_M1 = 4'(SETTLE - 1);
   localparam logic [N_IN-1:0] VEC_LAST  = '1;

   state_t          state_q, state_d;
   logic [2:0]      mode_q, mode_d;
   logic [N_IN-1:0] vec_q, vec_d;
   logic [3:0]      settle_q, settle_d;
   logic [N_IN:0]   err_q, err_d;
   logic [N_IN-1:0] ffv_q, ffv_d;
   logic            ffvalid_q, ffvalid_d;
   logic            pass_q, pass_d;
   logic            cfg_err_q, cfg_err_d;

   logic            ref_y;
   logic            miss;

   always_comb begin
      ref_y = 1'b0;
      case (mode_q)
         3'b000:  ref_y = &vec_q;
         3'b001:  ref_y = |vec_q;
         3'b010:  ref_y = ^vec_q;
         3'b011:  ref_y = ~&vec_q;
         3'b100:  ref_y = ~|vec_q;
         3'b101:  ref_y = ~^vec_q;
         default: ref_y = 1'b0;
      endcase
   end

   assign miss = (dut_y != ref_y);

   always_comb begin
      state_d   = state_q;
      mode_d    = mode_q;
      vec_d     = vec_q;
      settle_d  = settle_q;
      err_d     = err_q;
      ffv_d     = ffv_q;
      ffvalid_d = ffvalid_q;
      pass_d    = pass_q;
      cfg_err_d = 1'b0;
      case (state_q)
         ST_IDLE: begin
            // abort in the same cycle drops the start entirely
            if (start && !abort) begin
               if (mode < 3'd6) begin
                  state_d   = ST_RUN;
                  mode_d    = mode;
                  vec_d     = '0;
                  settle_d  = SETTLE_M1;
                  err_d     = '0;
                  ffv_d     = '0;
                  ffvalid_d = 1'b0;
                  pass_d    = 1'b0;
               end else begin
                  cfg_err_d = 1'b1;
               end
            end
         end
         ST_RUN: begin
            if (abort) begin
               state_d = ST_IDLE;
               vec_d   = '0;
               pass_d  = 1'b0;
            end else if (settle_q == 4'd0) begin
               if (miss) begin
                  err_d = err_q + 1'b1;
                  if (!ffvalid_q) begin
                     ffv_d     = vec_q;
                     ffvalid_d = 1'b1;
                  end
               end
               if (vec_q == VEC_LAST) begin
                  state_d = ST_DONE;
                  vec_d   = '0;
                  pass_d  = (err_d == '0);
               end else begin
                  vec_d    = vec_q + 1'b1;
                  settle_d = SETTLE_M1;
               end
            end else begin
               settle_d = settle_q - 1'b1;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         mode_q    <= 3'b000;
         vec_q     <= '0;
         settle_q  <= 4'd0;
         err_q     <= '0;
         ffv_q     <= '0;
         ffvalid_q <= 1'b0;
         pass_q    <= 1'b0;
         cfg_err_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         mode_q    <= mode_d;
         vec_q     <= vec_d;
         settle_q  <= settle_d;
         err_q     <= err_d;
         ffv_q     <= ffv_d;
         ffvalid_q <= ffvalid_d;
         pass_q    <= pass_d;
         cfg_err_q <= cfg_err_d;
      end
   end

   assign dut_in           = vec_q;
   assign busy             = (state_q == ST_RUN);
   assign done             = (state_q == ST_DONE);
   assign pass             = pass_q;
   assign err_count        = err_q;
   assign first_fail_vec   = ffv_q;
   assign first_fail_valid = ffvalid_q;
   assign cfg_err          = cfg_err_q;

endmodule

// File: tb/tb_gate_sweep_checker.sv
module tb_gate_sweep_checker;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       abort = 1'b0;
   logic [2:0] mode = 3'b000;
   logic       start0 = 1'b0, start1 = 1'b0, start2 = 1'b0;
   int         gate_kind0 = 0;

   // instance 0: N_IN=2 SETTLE=1, combinational AND or stuck-at-0 gate
   logic [1:0] dut_in0;
   logic       dut_y0, busy0, done0, pass0, ffvalid0, cfg_err0;
   logic [2:0] err0;
   logic [1:0] ffv0;
   // instances 1/2: N_IN=3, SETTLE=2 / SETTLE=1, registered NOR gate
   logic [2:0] dut_in1, dut_in2, ffv1, ffv2;
   logic       y1 = 1'b1, y2 = 1'b1;
   logic       busy1, done1, pass1, ffvalid1, cfg_err1;
   logic       busy2, done2, pass2, ffvalid2, cfg_err2;
   logic [3:0] err1, err2;

   always #5 clk = ~clk;

   assign dut_y0 = (gate_kind0 == 1) ? 1'b0 : &dut_in0;
   always @(posedge clk) y1 <= ~|dut_in1;
   always @(posedge clk) y2 <= ~|dut_in2;

   gate_sweep_checker #(.N_IN(2), .SETTLE(1)) u_dut0 (
      .clk(clk), .rst(rst), .start(start0), .abort(abort), .mode(mode),
      .dut_in(dut_in0), .dut_y(dut_y0), .busy(busy0), .done(done0), .pass(pass0),
      .err_count(err0), .first_fail_vec(ffv0), .first_fail_valid(ffvalid0),
      .cfg_err(cfg_err0));

   gate_sweep_checker #(.N_IN(3), .SETTLE(2)) u_dut1 (
      .clk(clk), .rst(rst), .start(start1), .abort(abort), .mode(mode),
      .dut_in(dut_in1), .dut_y(y1), .busy(busy1), .done(done1), .pass(pass1),
      .err_count(err1), .first_fail_vec(ffv1), .first_fail_valid(ffvalid1),
      .cfg_err(cfg_err1));

   gate_sweep_checker #(.N_IN(3), .SETTLE(1)) u_dut2 (
      .clk(clk), .rst(rst), .start(start2), .abort(abort), .mode(mode),
      .dut_in(dut_in2), .dut_y(y2), .busy(busy2), .done(done2), .pass(pass2),
      .err_count(err2), .first_fail_vec(ffv2), .first_fail_valid(ffvalid2),
      .cfg_err(cfg_err2));

   int         inst_sel = 0;
   logic [2:0] obs_dut_in, obs_ffv;
   logic [3:0] obs_err;
   logic       obs_busy, obs_done, obs_pass, obs_ffvalid;

   always_comb begin
      obs_dut_in  = {1'b0, dut_in0};
      obs_ffv     = {1'b0, ffv0};
      obs_err     = {1'b0, err0};
      obs_busy    = busy0;
      obs_done    = done0;
      obs_pass    = pass0;
      obs_ffvalid = ffvalid0;
      if (inst_sel == 1) begin
         obs_dut_in = dut_in1; obs_ffv = ffv1; obs_err = err1; obs_busy = busy1;
         obs_done = done1; obs_pass = pass1; obs_ffvalid = ffvalid1;
      end else if (inst_sel == 2) begin
         obs_dut_in = dut_in2; obs_ffv = ffv2; obs_err = err2; obs_busy = busy2;
         obs_done = done2; obs_pass = pass2; obs_ffvalid = ffvalid2;
      end
   end

   typedef struct {
      int err;
      int ffv;
      int ffvalid;
      int pass;
      int len;
   } exp_t;

   exp_t sb_q[$];
   int   n_checks = 0;
   int   n_errors = 0;

   task automatic chk(input string tag, input int got, input int expv);
      n_checks++;
      if (got != expv) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, expv, $time);
      end
   endtask

   function automatic int ref_fn(input logic [2:0] md, input int v, input int n);
      int msk, par;
      msk = (1 << n) - 1;
      par = 0;
      for (int b = 0; b < n; b++) par ^= (v >> b) & 1;
      case (md)
         3'b000:  return (v == msk) ? 1 : 0;
         3'b001:  return (v != 0) ? 1 : 0;
         3'b010:  return par;
         3'b011:  return (v == msk) ? 0 : 1;
         3'b100:  return (v != 0) ? 0 : 1;
         default: return 1 - par;
      endcase
   endfunction

   // kind 0: correct AND, 1: stuck-at-0, 2: NOR with one register of latency
   function automatic exp_t model(input int inst, input logic [2:0] md, input int kind);
      exp_t e;
      int n, s, y, prev;
      n = (inst == 0) ? 2 : 3;
      s = (inst == 1) ? 2 : 1;
      e.err = 0; e.ffv = 0; e.ffvalid = 0;
      e.len = (1 << n) * s;
      prev = 0;
      for (int v = 0; v < (1 << n); v++) begin
         if (kind == 0)      y = (v == (1 << n) - 1) ? 1 : 0;
         else if (kind == 1) y = 0;
         else                y = (((s >= 2) ? v : prev) == 0) ? 1 : 0;
         prev = v;
         if (y != ref_fn(md, v, n)) begin
            e.err++;
            if (e.ffvalid == 0) begin
               e.ffv = v;
               e.ffvalid = 1;
            end
         end
      end
      e.pass = (e.err == 0) ? 1 : 0;
      return e;
   endfunction

   task automatic set_start(input int inst, input logic v);
      if (inst == 0) start0 = v;
      else if (inst == 1) start1 = v;
      else start2 = v;
   endtask

   task automatic run_sweep(input int inst, input logic [2:0] md, input int kind, input int hold);
      exp_t e;
      int   cyc, s;
      s = (inst == 1) ? 2 : 1;
      inst_sel = inst;
      if (inst == 0) gate_kind0 = kind;
      sb_q.push_back(model(inst, md, kind));
      @(negedge clk);
      mode = md;
      set_start(inst, 1'b1);
      @(posedge clk); #1;
      if (hold == 0) set_start(inst, 1'b0);
      chk("pass_clr_at_start", obs_pass, 0);
      chk("err_clr_at_start", obs_err, 0);
      cyc = 0;
      while (!obs_done && cyc < 64) begin
         chk("busy_run", obs_busy, 1);
         chk("dut_in_seq", obs_dut_in, cyc / s);
         // mode changes mid-run must not affect the latched reference
         if (cyc == 1) mode = ~md;
         @(posedge clk); #1;
         cyc++;
      end
      set_start(inst, 1'b0);
      chk("latency", cyc, (inst == 0) ? 4 : 8 * s);
      chk("busy_at_done", obs_busy, 0);
      chk("dut_in_at_done", obs_dut_in, 0);
      if (sb_q.size() == 0) begin
         chk("sb_empty", 1, 0);
      end else begin
         e = sb_q.pop_front();
         chk("err_count", obs_err, e.err);
         chk("first_fail_vec", obs_ffv, e.ffv);
         chk("first_fail_valid", obs_ffvalid, e.ffvalid);
         chk("pass", obs_pass, e.pass);
      end
      @(posedge clk); #1;
      chk("done_one_cycle", obs_done, 0);
      chk("busy_after_done", obs_busy, 0);
      chk("pass_held", obs_pass, e.pass);
   endtask

   task automatic chk_reset0(input string tag);
      chk({tag, "_dut_in"}, dut_in0, 0);
      chk({tag, "_busy"}, busy0, 0);
      chk({tag, "_done"}, done0, 0);
      chk({tag, "_pass"}, pass0, 0);
      chk({tag, "_err"}, err0, 0);
      chk({tag, "_ffv"}, ffv0, 0);
      chk({tag, "_ffvalid"}, ffvalid0, 0);
      chk({tag, "_cfg_err"}, cfg_err0, 0);
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1;
      chk_reset0("reset");
      @(negedge clk);
      rst = 1'b0;
      repeat (2) @(posedge clk);

      run_sweep(0, 3'b000, 0, 0);   // AND, correct gate
      run_sweep(0, 3'b000, 1, 0);   // AND, stuck-at-0
      run_sweep(0, 3'b010, 0, 0);   // XOR against AND gate
      run_sweep(0, 3'b101, 1, 0);   // XNOR against stuck-at-0
      run_sweep(1, 3'b100, 2, 0);   // NOR, latency 1, SETTLE=2
      run_sweep(2, 3'b100, 2, 0);   // NOR, latency 1, SETTLE=1

      // abort on the third RUN cycle: samples of v0 and v1 only
      inst_sel = 0;
      gate_kind0 = 1;
      @(negedge clk);
      mode = 3'b001;
      start0 = 1'b1;
      @(posedge clk); #1;
      start0 = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      abort = 1'b1;
      @(posedge clk); #1;
      abort = 1'b0;
      chk("abort_busy", busy0, 0);
      chk("abort_dut_in", dut_in0, 0);
      chk("abort_done", done0, 0);
      chk("abort_pass", pass0, 0);
      chk("abort_err_partial", err0, 1);
      chk("abort_ffv_partial", ffv0, 1);
      chk("abort_ffvalid_partial", ffvalid0, 1);
      repeat (3) begin
         @(posedge clk); #1;
         chk("abort_no_done", done0, 0);
      end
      run_sweep(0, 3'b000, 0, 0);

      // reset mid-sweep
      @(negedge clk);
      mode = 3'b010;
      start0 = 1'b1;
      @(posedge clk); #1;
      start0 = 1'b0;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk_reset0("midrst");
      @(negedge clk);
      rst = 1'b0;

      // reserved modes
      for (int m = 6; m < 8; m++) begin
         @(negedge clk);
         mode = 3'(m);
         start0 = 1'b1;
         @(posedge clk); #1;
         start0 = 1'b0;
         chk("cfg_err_pulse", cfg_err0, 1);
         chk("cfg_err_busy", busy0, 0);
         @(posedge clk); #1;
         chk("cfg_err_one_cycle", cfg_err0, 0);
      end

      // start and abort together in IDLE
      @(negedge clk);
      mode = 3'b000;
      start0 = 1'b1;
      abort = 1'b1;
      @(posedge clk); #1;
      start0 = 1'b0;
      abort = 1'b0;
      chk("start_abort_busy", busy0, 0);
      chk("start_abort_cfg_err", cfg_err0, 0);

      // start held high through the sweep, NAND against AND
      run_sweep(0, 3'b011, 0, 1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not reach its end");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/gate_sweep_checker.md
# gate_sweep_checker

Self-checking stimulus engine for single-output logic gates. It drives every one of the 2^N_IN input combinations onto a gate under test in ascending binary order, holding each one for a programmable settle time. It samples the gate output and compares it against an internal reference model chosen by a mode select. At the end of the sweep it reports pass/fail, the mismatch count and the first failing vector. It sits between a gate-level block and the bench or on-chip BIST wrapper, replacing hand-written vector sequences.

## Interface
- N_IN, default 2: gate input count, legal range 1..8.
- SETTLE, default 1: cycles each vector is held before its output is sampled, legal range 1..15.
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request to begin a sweep; honoured only in IDLE.
- abort  in  1  terminates a running sweep.
- mode  in  3  reference function: 000 AND, 001 OR, 010 XOR, 011 NAND, 100 NOR, 101 XNOR, 110/111 reserved.
- dut_in  out  N_IN  registered stimulus to the gate under test.
- dut_y  in  1  gate-under-test output.
- busy  out  1  high while a sweep runs.
- done  out  1  one-cycle pulse when a sweep completes (not on abort).
- pass  out  1  1 when the last completed sweep had zero mismatches; held until the next accepted start.
- err_count  out  N_IN+1  number of mismatches; cannot overflow, so no saturation.
- first_fail_vec  out  N_IN  first vector that mismatched.
- first_fail_valid  out  1  first_fail_vec holds a captured value.
- cfg_err  out  1  one-cycle pulse when start arrives with a reserved mode.

## Operation
- FSM states:
  - IDLE: on start with a legal mode, move to RUN. On start with a reserved mode, stay in IDLE and pulse cfg_err.
  - RUN: advance through the vectors. After the final sample move to DONE; on abort move to IDLE.
  - DONE: lasts one cycle, then IDLE.
- On an accepted start:
  - mode is latched into an internal register; changes on mode during RUN are ignored.
  - err_count, first_fail_vec, first_fail_valid and pass are cleared.
  - dut_in is set to 0.
- Reference model for a vector v is a reduction over all N_IN bits: &v, |v, ^v and their complements. With N_IN=1, AND/OR/XOR reduce to v[0].
- At each sample point, if dut_y differs from the expected value:
  - err_count increments.
  - If first_fail_valid=0, capture v into first_fail_vec and set first_fail_valid=1.
- start while busy is ignored.
- abort in IDLE is ignored. If start and abort arrive in the same IDLE cycle, abort wins and the start is dropped.
- Abort during RUN, at the next edge:
  - busy=0, dut_in=0, no done, pass=0.
  - err_count and first_fail_* keep their partial values.
- Reset values of all outputs: dut_in=0, busy=0, done=0, pass=0, err_count=0, first_fail_vec=0, first_fail_valid=0, cfg_err=0. The FSM returns to IDLE. Reset mid-sweep discards all results.

## Timing
- Let S be the edge that accepts start. At S: busy=1, dut_in=0.
- Vector k (k=0..2^N_IN−1) is on dut_in from edge S+k·SETTLE. dut_y is sampled at edge S+(k+1)·SETTLE, the same edge at which dut_in moves to k+1.
- A DUT with pipeline latency L is checked correctly when SETTLE ≥ L+1 (L=0 means combinational).
- At the final sample edge S+2^N_IN·SETTLE:
  - busy=0, done=1, dut_in=0.
  - pass = (err_count including the final compare == 0).
- Start-to-done latency is exactly 2^N_IN·SETTLE cycles. busy is high for exactly that many cycles.
- The next start is accepted at the edge after done (the DONE cycle ignores start).
- cfg_err asserts at the edge after the rejected start and lasts one cycle.

## Test plan
- N_IN=2, SETTLE=1, mode AND, correct AND DUT → dut_in steps 0,1,2,3 on consecutive cycles; done 4 cycles after start; pass=1, err_count=0, first_fail_valid=0.
- Same configuration, DUT output stuck at 0 → err_count=1, first_fail_vec=3, pass=0.
- N_IN=2, mode XOR against a correct AND DUT → err_count=3, first_fail_vec=1, pass=0.
- N_IN=3, SETTLE=2, mode NOR, DUT with 1-cycle registered output → busy for 16 cycles, pass=1. Repeat with SETTLE=1 → pass=0.
- Abort on the 3rd RUN cycle → next edge busy=0, dut_in=0, no done pulse, pass=0. A subsequent start completes normally. rst pulsed mid-sweep → every output at its reset value immediately.
- mode=110 with start → cfg_err pulses once, busy stays 0. start held high throughout a sweep → exactly one sweep runs and a single done pulse is produced.
